// File: rtl/fpga_mon_pkg.sv
// Shared types, button map and seven-segment encoding for the memory monitor.
package fpga_mon_pkg;

    typedef enum logic [2:0] {
        CPU_OWN,
        STALL,
        POLL_WAIT,
        READ_REQ,
        RELEASE
    } state_t;

    typedef enum logic {
        MODE_ADDR,
        MODE_DATA
    } mode_t;

    localparam int PB_MODE = 16;
    localparam int PB_STEP = 17;
    localparam int PB_OWN  = 18;

    // Segments g..a for hex 0..F; dp is added separately
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return {1'b0, SEG_HEX[nib]};
    endfunction

endpackage

// File: rtl/fpga_mem_monitor_pb_edge.sv
// Two-flop synchroniser per button followed by a rising-edge detector.
module pb_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] sync2_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_q <= '0;
        end else begin
            sync1   <= d;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/fpga_mem_monitor.sv
// Debug monitor: takes the data memory port from the CPU, polls one word and
// shows its address or contents on seven-segment digits.
module fpga_mem_monitor
    import fpga_mon_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int NUM_PB     = 21,
    parameter int POLL_DIV   = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PB-1:0]       pb,
    input  logic                    cpu_idle,
    output logic                    cpu_stall,
    output logic                    mon_sel,
    output logic [ADDR_W-1:0]       mon_addr,
    output logic                    mon_ren,
    input  logic [DATA_W-1:0]       mon_rdata,
    input  logic                    mon_ack,
    output logic [NUM_DIGITS*8-1:0] ss,
    output logic                    owned_led,
    output logic                    err_led
);

    localparam int PW = $clog2(POLL_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Digits whose nibble lies wholly beyond the source width stay dark.
    function automatic logic [NUM_DIGITS*8-1:0] render(input logic [63:0] src,
                                                       input int width,
                                                       input logic dp);
        logic [NUM_DIGITS*8-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i * 4 < width) r[i*8 +: 8] = hex_to_seg(src[i*4 +: 4]);
        end
        r[7] = r[7] | dp;
        return r;
    endfunction

    localparam logic [NUM_DIGITS*8-1:0] SS_RST = render(64'd0, ADDR_W, 1'b0);

    logic [NUM_PB-1:0] rise;
    logic              unused_rise;
    logic              ev_own, ev_step, ev_mode, ev_digit;
    logic              digit_hit;
    logic [3:0]        digit;

    state_t            state, state_next;
    mode_t             mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PW-1:0]     poll_cnt;
    logic [TW-1:0]     to_cnt;
    logic              ack_hit, to_hit;

    pb_edge #(.W(NUM_PB)) u_pb_edge (
        .clk   (clk),
        .reset (reset),
        .d     (pb),
        .rise  (rise)
    );

    // Buttons above the own/release button have no function.
    assign unused_rise = ^(rise >> 19);

    always_comb begin
        digit     = '0;
        digit_hit = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (rise[i]) begin
                digit     = 4'(i);
                digit_hit = 1'b1;
            end
        end
    end

    assign ev_own   = rise[PB_OWN];
    assign ev_step  = rise[PB_STEP] && !ev_own;
    assign ev_mode  = rise[PB_MODE] && !rise[PB_STEP] && !ev_own;
    assign ev_digit = digit_hit && !rise[PB_MODE] && !rise[PB_STEP] && !ev_own;

    assign ack_hit = (state == READ_REQ) && mon_ack;
    assign to_hit  = (state == READ_REQ) && !mon_ack && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CPU_OWN;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        mon_sel    = 1'b0;
        mon_ren    = 1'b0;
        unique case (state)
            CPU_OWN: begin
                if (ev_own) state_next = STALL;
            end
            STALL: begin
                cpu_stall = 1'b1;
                if (cpu_idle) state_next = POLL_WAIT;
            end
            POLL_WAIT: begin
                cpu_stall = 1'b1;
                mon_sel   = 1'b1;
                if (ev_own)               state_next = RELEASE;
                else if (poll_cnt == '0)  state_next = READ_REQ;
            end
            READ_REQ: begin
                cpu_stall = 1'b1;
                mon_sel   = 1'b1;
                mon_ren   = 1'b1;
                if (ack_hit || to_hit) state_next = POLL_WAIT;
            end
            RELEASE: begin
                cpu_stall  = 1'b1;
                state_next = CPU_OWN;
            end
            default: state_next = CPU_OWN;
        endcase
    end

    assign owned_led = mon_sel;

    // Poll counter is preloaded outside POLL_WAIT so it is ready on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= PW'(POLL_DIV - 1);
            to_cnt   <= '0;
        end else begin
            if (state != POLL_WAIT)   poll_cnt <= PW'(POLL_DIV - 1);
            else if (poll_cnt != '0)  poll_cnt <= poll_cnt - PW'(1);
            if (state == READ_REQ)    to_cnt   <= to_cnt + TW'(1);
            else                      to_cnt   <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            mode     <= MODE_ADDR;
            data     <= '0;
            err_led  <= 1'b0;
            mon_addr <= '0;
        end else begin
            if (ev_step)       addr <= addr + ADDR_W'(4);
            else if (ev_digit) addr <= {addr[ADDR_W-5:0], digit};
            if (ev_mode)       mode <= (mode == MODE_ADDR) ? MODE_DATA : MODE_ADDR;

            if (ack_hit) begin
                data    <= mon_rdata;
                err_led <= 1'b0;
            end else if (to_hit) begin
                err_led <= 1'b1;
            end

            // Latch the entered address only as a read begins, keeping it stable.
            if (state != READ_REQ && state_next == READ_REQ) mon_addr <= addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss <= SS_RST;
        end else if (mode == MODE_DATA) begin
            ss <= render(64'(data), DATA_W, err_led);
        end else begin
            ss <= render(64'(addr), ADDR_W, err_led);
        end
    end

endmodule
